// File: rtl/dh_pkg.sv
// Shared types and timing helpers for the Diffie-Hellman key engine.
// DH_CROSSCHECK_EN adds the CHK state; dh_latency() accounts for it when asked.
package dh_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RED,
    S_EXPA,
    S_EXPB,
    S_EXPS,
    S_CHK,
    S_FIN
  } dh_state_e;

  typedef enum logic {
    PH_SQR,
    PH_MUL
  } dh_phase_e;

  localparam int unsigned DH_DEFAULT_WIDTH = 32;

  function automatic int unsigned mm_cycles(input int unsigned width);
    return width + 1;
  endfunction

  localparam int unsigned MM_CYCLES = mm_cycles(DH_DEFAULT_WIDTH);

  function automatic int unsigned dh_latency(input int unsigned width, input bit crosscheck);
    int unsigned muls;
    muls = 1 + 6 * width + (crosscheck ? 2 * width : 0);
    return muls * mm_cycles(width) + 1;
  endfunction

endpackage

// File: rtl/dh_modmul.sv
// Serial interleaved shift-add modular multiplier: r = a*b mod p in WIDTH+1 cycles.
// Requires b < p; a is unrestricted. done pulses the cycle r is final.
module dh_modmul #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             done,
  output logic [WIDTH-1:0] r
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d, r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH:0]   t_dbl, t_red, t_sum, t_fin;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    p_d    = p_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;

    // Intermediates stay below 2p, so WIDTH+1 bits never overflow
    t_dbl = {r_q, 1'b0};
    t_red = (t_dbl >= {1'b0, p_q}) ? t_dbl - {1'b0, p_q} : t_dbl;
    t_sum = t_red + (a_q[cnt_q] ? {1'b0, b_q} : '0);
    t_fin = (t_sum >= {1'b0, p_q}) ? t_sum - {1'b0, p_q} : t_sum;

    if (start) begin
      a_d    = a;
      b_d    = b;
      p_d    = p;
      r_d    = '0;
      cnt_d  = CW'(WIDTH - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      r_d = t_fin[WIDTH-1:0];
      if (cnt_q == '0) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      p_q    <= p_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign r    = r_q;

endmodule

// File: rtl/dh_key_engine.sv
// Constant-time Diffie-Hellman engine: PUB_A = G^X, PUB_B = G^Y, KEY = PUB_B^X (mod P).
// Optional macro DH_CROSSCHECK_EN recomputes PUB_A^Y and flags MISMATCH against KEY.
module dh_key_engine
  import dh_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ST,
  input  logic [WIDTH-1:0] G,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] PUB_A,
  output logic [WIDTH-1:0] PUB_B,
  output logic [WIDTH-1:0] KEY,
  output logic             ERR,
  output logic             MISMATCH
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] TOP_BIT = CW'(WIDTH - 1);

  dh_state_e        state_q, state_d;
  dh_phase_e        phase_q, phase_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] acc_q, acc_d, g_q, g_d, p_q, p_d, x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0] res_a_q, res_a_d, res_b_q, res_b_d, res_k_q, res_k_d;
  logic [WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d, out_k_q, out_k_d;
  logic             out_err_q, out_err_d, done_q, done_d;
`ifdef DH_CROSSCHECK_EN
  logic [WIDTH-1:0] res_c_q, res_c_d;
  logic             out_mis_q, out_mis_d;
`endif

  logic             mm_start, mm_done;
  logic [WIDTH-1:0] mm_a, mm_b, mm_p, mm_r, exp_val, base_d, final_r;

  dh_modmul #(.WIDTH(WIDTH)) u_modmul (
    .clk   (CLK),
    .rst_n (RST),
    .start (mm_start),
    .a     (mm_a),
    .b     (mm_b),
    .p     (mm_p),
    .done  (mm_done),
    .r     (mm_r)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    acc_d     = acc_q;
    g_d       = g_q;
    p_d       = p_q;
    x_d       = x_q;
    y_d       = y_q;
    res_a_d   = res_a_q;
    res_b_d   = res_b_q;
    res_k_d   = res_k_q;
    out_a_d   = out_a_q;
    out_b_d   = out_b_q;
    out_k_d   = out_k_q;
    out_err_d = out_err_q;
    done_d    = 1'b0;
`ifdef DH_CROSSCHECK_EN
    res_c_d   = res_c_q;
    out_mis_d = out_mis_q;
`endif
    mm_start  = 1'b0;
    exp_val   = (state_q == S_EXPB || state_q == S_CHK) ? y_q : x_q;
    final_r   = exp_val[bit_q] ? mm_r : acc_q;

    case (state_q)
      S_IDLE: begin
        if (ST && !done_q) begin
          g_d     = G;
          p_d     = P;
          x_d     = X;
          y_d     = Y;
          res_a_d = '0;
          res_b_d = '0;
          res_k_d = '0;
`ifdef DH_CROSSCHECK_EN
          res_c_d = '0;
`endif
          if (P < WIDTH'(2)) begin
            state_d = S_FIN;
          end else begin
            state_d  = S_RED;
            mm_start = 1'b1;
          end
        end
      end
      S_RED: begin
        if (mm_done) begin
          g_d      = mm_r;
          state_d  = S_EXPA;
          acc_d    = WIDTH'(1);
          bit_d    = TOP_BIT;
          phase_d  = PH_SQR;
          mm_start = 1'b1;
        end
      end
      S_EXPA, S_EXPB, S_EXPS, S_CHK: begin
        if (mm_done) begin
          // The multiply by base is always performed; only the select depends on the bit
          if (phase_q == PH_SQR) begin
            acc_d   = mm_r;
            phase_d = PH_MUL;
          end else if (bit_q != '0) begin
            acc_d   = final_r;
            bit_d   = bit_q - 1'b1;
            phase_d = PH_SQR;
          end else begin
            acc_d   = WIDTH'(1);
            bit_d   = TOP_BIT;
            phase_d = PH_SQR;
            case (state_q)
              S_EXPA:  begin res_a_d = final_r; state_d = S_EXPB; end
              S_EXPB:  begin res_b_d = final_r; state_d = S_EXPS; end
`ifdef DH_CROSSCHECK_EN
              S_EXPS:  begin res_k_d = final_r; state_d = S_CHK;  end
              default: begin res_c_d = final_r; state_d = S_FIN;  end
`else
              default: begin res_k_d = final_r; state_d = S_FIN;  end
`endif
            endcase
          end
          mm_start = (state_d != S_FIN);
        end
      end
      S_FIN: begin
        state_d   = S_IDLE;
        done_d    = 1'b1;
        out_a_d   = res_a_q;
        out_b_d   = res_b_q;
        out_k_d   = res_k_q;
        out_err_d = (p_q < WIDTH'(2));
`ifdef DH_CROSSCHECK_EN
        out_mis_d = (res_c_q != res_k_q);
`endif
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_EXPS:  base_d = res_b_d;
      S_CHK:   base_d = res_a_d;
      default: base_d = g_d;
    endcase

    // First multiply is fed straight from the ports so no cycle is lost on accept
    if (state_q == S_IDLE) begin
      mm_a = G;
      mm_b = WIDTH'(1);
      mm_p = P;
    end else begin
      mm_a = acc_d;
      mm_b = (phase_d == PH_SQR) ? acc_d : base_d;
      mm_p = p_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_SQR;
      bit_q     <= '0;
      acc_q     <= '0;
      g_q       <= '0;
      p_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      res_a_q   <= '0;
      res_b_q   <= '0;
      res_k_q   <= '0;
      out_a_q   <= '0;
      out_b_q   <= '0;
      out_k_q   <= '0;
      out_err_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef DH_CROSSCHECK_EN
      res_c_q   <= '0;
      out_mis_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_q     <= bit_d;
      acc_q     <= acc_d;
      g_q       <= g_d;
      p_q       <= p_d;
      x_q       <= x_d;
      y_q       <= y_d;
      res_a_q   <= res_a_d;
      res_b_q   <= res_b_d;
      res_k_q   <= res_k_d;
      out_a_q   <= out_a_d;
      out_b_q   <= out_b_d;
      out_k_q   <= out_k_d;
      out_err_q <= out_err_d;
      done_q    <= done_d;
`ifdef DH_CROSSCHECK_EN
      res_c_q   <= res_c_d;
      out_mis_q <= out_mis_d;
`endif
    end
  end

  assign BUSY  = (state_q != S_IDLE) || done_q;
  assign DONE  = done_q;
  assign PUB_A = out_a_q;
  assign PUB_B = out_b_q;
  assign KEY   = out_k_q;
  assign ERR   = out_err_q;
`ifdef DH_CROSSCHECK_EN
  assign MISMATCH = out_mis_q;
`else
  assign MISMATCH = 1'b0;
`endif

endmodule

// File: tb/tb_dh_key_engine.sv
// Randomised self-checking bench for dh_key_engine at WIDTH=8 against an
// LSB-first modular-exponentiation reference model.
module tb_dh_key_engine;
  localparam int unsigned W = 8;
`ifdef DH_CROSSCHECK_EN
  localparam int unsigned MULS = 1 + 8 * W;
`else
  localparam int unsigned MULS = 1 + 6 * W;
`endif
  localparam int unsigned LAT    = MULS * (W + 1) + 1;
  localparam int unsigned BUDGET = 2 * LAT + 50;

  logic         clk = 1'b0;
  logic         rst_n, st;
  logic [W-1:0] g, p, x, y;
  logic         busy, done, err, mism;
  logic [W-1:0] pub_a, pub_b, key;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  dh_key_engine #(.WIDTH(W)) dut (
    .CLK      (clk),
    .RST      (rst_n),
    .ST       (st),
    .G        (g),
    .P        (p),
    .X        (x),
    .Y        (y),
    .BUSY     (busy),
    .DONE     (done),
    .PUB_A    (pub_a),
    .PUB_B    (pub_b),
    .KEY      (key),
    .ERR      (err),
    .MISMATCH (mism)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_pow(input logic [W-1:0] base, input logic [W-1:0] e_in,
                                           input logic [W-1:0] m);
    longint unsigned r, b, e;
    r = 1;
    b = base % m;
    e = e_in;
    while (e != 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return W'(r % m);
  endfunction

  task automatic start_run(input logic [W-1:0] gi, pi, xi, yi);
    @(negedge clk);
    g  = gi;
    p  = pi;
    x  = xi;
    y  = yi;
    st = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
  endtask

  task automatic wait_done(input bit disturb, output int unsigned lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < BUDGET) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) seen = 1'b1;
      else if (disturb && lat == 50) begin
        st = 1'b1;
        g  = W'($urandom);
        p  = W'($urandom);
        x  = W'($urandom);
        y  = W'($urandom);
      end else if (disturb && lat == 51) st = 1'b0;
    end
  endtask

  task automatic verify(input string name, input logic [W-1:0] gi, pi, xi, yi, input bit disturb);
    int unsigned  lat;
    bit           seen;
    bit           bad_p;
    logic [W-1:0] ea, eb, ek;
    bad_p = (pi < 2);
    ea = bad_p ? '0 : ref_pow(gi, xi, pi);
    eb = bad_p ? '0 : ref_pow(gi, yi, pi);
    ek = bad_p ? '0 : ref_pow(eb, xi, pi);
    start_run(gi, pi, xi, yi);
    check($sformatf("%s_busy", name), busy, 1);
    wait_done(disturb, lat, seen);
    check($sformatf("%s_done_seen", name), seen, 1);
    check($sformatf("%s_latency", name), lat, bad_p ? 1 : LAT);
    check($sformatf("%s_pub_a", name), pub_a, ea);
    check($sformatf("%s_pub_b", name), pub_b, eb);
    check($sformatf("%s_key", name), key, ek);
    check($sformatf("%s_err", name), err, bad_p);
    check($sformatf("%s_mismatch", name), mism, 0);
    @(posedge clk);
    #1;
    check($sformatf("%s_done_pulse", name), done, 0);
    check($sformatf("%s_busy_clr", name), busy, 0);
  endtask

  initial begin
    int unsigned lat;
    bit          seen;
    bit          got_done;

    rst_n = 1'b0;
    st    = 1'b0;
    g     = '0;
    p     = '0;
    x     = '0;
    y     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pub_a", pub_a, 0);
    check("rst_pub_b", pub_b, 0);
    check("rst_key", key, 0);
    check("rst_err", err, 0);
    check("rst_mismatch", mism, 0);
    rst_n = 1'b1;

    verify("p5", 8'd17, 8'd5, 8'd6, 8'd8, 1'b0);
    check("p5_key_const", key, 1);
    verify("p23", 8'd5, 8'd23, 8'd4, 8'd3, 1'b0);
    check("p23_key_const", key, 18);
    verify("p23_x0", 8'd5, 8'd23, 8'd0, 8'd3, 1'b0);
    verify("p1_err", 8'd5, 8'd1, 8'd4, 8'd3, 1'b0);
    verify("after_err", 8'd5, 8'd23, 8'd4, 8'd3, 1'b0);
    verify("disturb", 8'd7, 8'd251, 8'd200, 8'd99, 1'b1);

    // Reset part way through a run
    start_run(8'd11, 8'd97, 8'd55, 8'd77);
    repeat (99) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_pub_a", pub_a, 0);
    check("midrst_pub_b", pub_b, 0);
    check("midrst_key", key, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    rst_n    = 1'b1;
    got_done = 1'b0;
    repeat (LAT + 20) begin
      @(posedge clk);
      #1;
      if (done) got_done = 1'b1;
    end
    check("midrst_no_done", got_done, 0);
    verify("post_rst", 8'd11, 8'd97, 8'd55, 8'd77, 1'b0);

    for (int i = 0; i < 6; i++) begin
      verify($sformatf("rnd%0d", i), W'($urandom), W'($urandom_range(255, 2)),
             W'($urandom), W'($urandom), 1'b0);
    end

`ifdef DH_CROSSCHECK_EN
    start_run(8'd5, 8'd23, 8'd4, 8'd3);
    lat = 0;
    while (dut.state_q != dh_pkg::S_CHK && lat < BUDGET) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("force_reach_chk", dut.state_q == dh_pkg::S_CHK, 1);
    force dut.res_k_q = 8'd0;
    wait_done(1'b0, lat, seen);
    check("force_done_seen", seen, 1);
    check("force_mismatch", mism, 1);
    release dut.res_k_q;
    verify("post_force", 8'd5, 8'd23, 8'd4, 8'd3, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
